mem_port_arbiter: RTL

Two-requester arbiter that shares the single-port 4096×32 data memory between the CPU data port and a host/debug loader port. It sits between `instruction_set_model`'s data-memory interface and the memory array. It sequences each access through a small state machine and grants round-robin when both sides request. It returns read data and a one-cycle acknowledge to the winning requester, and keeps a saturating count of contention events for debug.

---
 rtl/mem_port_arbiter_if.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the CPU/host requesters, the arbiter and the data memory.
// master = arbiter side, slave = requesters plus memory array.
interface mem_port_arbiter_if #(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned ADDRSIZE = 12
);
   logic                cpu_req;
   logic                cpu_we;
   logic [ADDRSIZE-1:0] cpu_addr;
   logic [0:WIDTH-1]    cpu_wdata;
   logic [0:WIDTH-1]    cpu_rdata;
   logic                cpu_ack;

   logic                host_req;
   logic                host_we;
   logic [ADDRSIZE-1:0] host_addr;
   logic [0:WIDTH-1]    host_wdata;
   logic [0:WIDTH-1]    host_rdata;
   logic                host_ack;

   logic [ADDRSIZE-1:0] MEM_ADDR;
   logic [0:WIDTH-1]    MEM_OUT;
   logic                MEM_CTRL;
   logic [0:WIDTH-1]    MEM_IN;

   modport master (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_ack,
      input  host_req, host_we, host_addr, host_wdata,
      output host_rdata, host_ack,
      output MEM_ADDR, MEM_OUT, MEM_CTRL,
      input  MEM_IN
   );

   modport slave (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_ack,
      output host_req, host_we, host_addr, host_wdata,
      input  host_rdata, host_ack,
      input  MEM_ADDR, MEM_OUT, MEM_CTRL,
      output MEM_IN
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the CPU and host ports.
// Every access is sequenced IDLE -> ADDR -> (WAIT for reads) -> DONE with registered outputs.
module mem_port_arbiter #(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned ADDRSIZE = 12,
   parameter int unsigned CNTW     = 8
) (
   input  logic                clk,
   input  logic                rst,
   mem_port_arbiter_if.master  bus,
   output logic [1:0]          grant,
   output logic                busy,
   output logic [CNTW-1:0]     conflict_cnt
);

   typedef enum logic [1:0] {StIdle, StAddr, StWait, StDone} state_e;

   state_e              r_state;
   logic                r_owner_host;
   logic                r_last_host;
   logic                r_we;
   logic [ADDRSIZE-1:0] r_mem_addr;
   logic [0:WIDTH-1]    r_mem_out;
   logic                r_mem_ctrl;
   logic [0:WIDTH-1]    r_cpu_rdata;
   logic [0:WIDTH-1]    r_host_rdata;
   logic                r_cpu_ack;
   logic                r_host_ack;
   logic [1:0]          r_grant;
   logic                r_busy;
   logic [CNTW-1:0]     r_conflict;

   logic                w_any;
   logic                w_both;
   logic                w_cpu_win;
   logic                w_sel_we;
   logic [ADDRSIZE-1:0] w_sel_addr;
   logic [0:WIDTH-1]    w_sel_wdata;

   // On contention the CPU wins only if the host was granted last.
   always_comb begin
      w_any       = bus.cpu_req | bus.host_req;
      w_both      = bus.cpu_req & bus.host_req;
      w_cpu_win   = bus.cpu_req & (~bus.host_req | r_last_host);
      w_sel_we    = w_cpu_win ? bus.cpu_we    : bus.host_we;
      w_sel_addr  = w_cpu_win ? bus.cpu_addr  : bus.host_addr;
      w_sel_wdata = w_cpu_win ? bus.cpu_wdata : bus.host_wdata;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= StIdle;
         r_owner_host <= 1'b0;
         r_last_host  <= 1'b1;
         r_we         <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_out    <= '0;
         r_mem_ctrl   <= 1'b0;
         r_cpu_rdata  <= '0;
         r_host_rdata <= '0;
         r_cpu_ack    <= 1'b0;
         r_host_ack   <= 1'b0;
         r_grant      <= 2'b00;
         r_busy       <= 1'b0;
         r_conflict   <= '0;
      end else begin
         r_cpu_ack  <= 1'b0;
         r_host_ack <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (w_both && (r_conflict != '1)) begin
                  r_conflict <= r_conflict + 1'b1;
               end
               if (w_any) begin
                  r_owner_host <= ~w_cpu_win;
                  r_last_host  <= ~w_cpu_win;
                  r_we         <= w_sel_we;
                  r_mem_addr   <= w_sel_addr;
                  r_mem_out    <= w_sel_wdata;
                  r_mem_ctrl   <= w_sel_we;
                  r_grant      <= w_cpu_win ? 2'b01 : 2'b10;
                  r_busy       <= 1'b1;
                  r_state      <= StAddr;
               end
            end
            StAddr: begin
               r_mem_ctrl <= 1'b0;
               if (r_we) begin
                  r_cpu_ack  <= ~r_owner_host;
                  r_host_ack <= r_owner_host;
                  r_state    <= StDone;
               end else begin
                  r_state <= StWait;
               end
            end
            StWait: begin
               // Memory data for the address presented in ADDR is valid now.
               if (r_owner_host) begin
                  r_host_rdata <= bus.MEM_IN;
               end else begin
                  r_cpu_rdata <= bus.MEM_IN;
               end
               r_cpu_ack  <= ~r_owner_host;
               r_host_ack <= r_owner_host;
               r_state    <= StDone;
            end
            StDone: begin
               r_grant <= 2'b00;
               r_busy  <= 1'b0;
               r_state <= StIdle;
            end
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

   assign bus.cpu_rdata  = r_cpu_rdata;
   assign bus.cpu_ack    = r_cpu_ack;
   assign bus.host_rdata = r_host_rdata;
   assign bus.host_ack   = r_host_ack;
   assign bus.MEM_ADDR   = r_mem_addr;
   assign bus.MEM_OUT    = r_mem_out;
   assign bus.MEM_CTRL   = r_mem_ctrl;
   assign grant          = r_grant;
   assign busy           = r_busy;
   assign conflict_cnt   = r_conflict;

endmodule
